// File: rtl/mips_cpu_tb_pkg.sv
// Shared types and helpers for the preloadable instruction memory.
// Holds the phase enum, reset vector, NOP encoding and the byte-reverse helper.
package mips_cpu_tb_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALT    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] NOP_WORD             = 32'h00000000;

  function automatic logic [31:0] byte_swap32(input logic [31:0] word);
    return {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

endpackage

// File: rtl/mips_cpu_read_pipe.sv
// Enable-gated delay line for the {valid, data} fetch result.
// A latency of zero collapses to a wire so the fetch stays combinational.
module mips_cpu_read_pipe #(
  parameter int LATENCY = 0,
  parameter int WIDTH   = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (LATENCY == 0) begin : g_bypass
      logic unused_s;
      assign unused_s = ^{clk, rst_n, en};
      assign dout     = din;
    end else begin : g_stages
      logic [WIDTH-1:0] stage_r [LATENCY];

      // Shift the fetch result one stage per enabled edge
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LATENCY; i++) begin
            stage_r[i] <= {WIDTH{1'b0}};
          end
        end else if (en) begin
          stage_r[0] <= din;
          for (int i = 1; i < LATENCY; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign dout = stage_r[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/mips_cpu_instr_memory.sv
// Preloadable instruction memory: streams a program in, then serves CPU fetches
// and monitors the run for halt, timeout and illegal fetch addresses.
module mips_cpu_instr_memory
  import mips_cpu_tb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = DEFAULT_RESET_VECTOR,
  parameter int          DEPTH_WORDS    = 64,
  parameter int          READ_LATENCY   = 0,
  parameter bit          BYTE_SWAP      = 1'b1,
  parameter int          TIMEOUT_CYCLES = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_done,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        instr_valid,
  input  logic        active,
  output logic        halted,
  output logic        timeout,
  output logic        addr_error,
  output logic [31:0] cycle_count
);

  localparam int              AW           = $clog2(DEPTH_WORDS);
  localparam logic [31:0]     SPAN         = 32'(4 * DEPTH_WORDS);
  localparam logic [AW-1:0]   LAST_IDX     = AW'(DEPTH_WORDS - 1);
  localparam logic [31:0]     TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t                 state_r, state_next_s;
  logic [AW-1:0]          ptr_r;
  logic [DEPTH_WORDS-1:0] valid_r;
  logic [31:0]            mem_r [DEPTH_WORDS];
  logic                   load_done_r, halted_r, timeout_r, addr_error_r;
  logic [31:0]            cycle_count_r;
  logic                   load_fire_s, halt_hit_s, timeout_hit_s, legal_s;
  logic [31:0]            off_s, word_s, fetch_s;
  logic [AW-1:0]          idx_s;
  logic                   pipe_valid_s;
  logic [31:0]            pipe_data_s;

  // Address decode and word lookup; unloaded or illegal words read as NOP
  always_comb begin
    off_s   = instr_address - BASE_ADDR;
    legal_s = (off_s < SPAN) && (off_s[1:0] == 2'b00);
    idx_s   = off_s[AW+1:2];
    word_s  = mem_r[idx_s];
    fetch_s = NOP_WORD;
    if (legal_s && valid_r[idx_s]) begin
      if (BYTE_SWAP) begin
        fetch_s = byte_swap32(word_s);
      end else begin
        fetch_s = word_s;
      end
    end else begin
      fetch_s = NOP_WORD;
    end
  end

  // Phase sequencing; halt takes priority over a coincident timeout
  always_comb begin
    state_next_s  = state_r;
    load_fire_s   = 1'b0;
    halt_hit_s    = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_LOAD: begin
        load_fire_s = load_valid;
        if (load_valid && (load_last || (ptr_r == LAST_IDX))) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        halt_hit_s    = (instr_address == 32'h00000000) && !active;
        timeout_hit_s = (cycle_count_r == TIMEOUT_LAST);
        if (halt_hit_s) begin
          state_next_s = ST_HALT;
        end else if (timeout_hit_s) begin
          state_next_s = ST_TIMEOUT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALT:    state_next_s = ST_HALT;
      ST_TIMEOUT: state_next_s = ST_TIMEOUT;
      default:    state_next_s = ST_LOAD;
    endcase
  end

  // Control state, load pointer, per-word valid bits and sticky run flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_LOAD;
      ptr_r         <= {AW{1'b0}};
      valid_r       <= {DEPTH_WORDS{1'b0}};
      load_done_r   <= 1'b0;
      halted_r      <= 1'b0;
      timeout_r     <= 1'b0;
      addr_error_r  <= 1'b0;
      cycle_count_r <= 32'd0;
    end else if (clk_enable) begin
      state_r <= state_next_s;
      if (load_fire_s) begin
        valid_r[ptr_r] <= 1'b1;
        ptr_r          <= ptr_r + AW'(1);
      end
      if (state_r == ST_LOAD && state_next_s == ST_RUN) begin
        load_done_r <= 1'b1;
      end
      if (state_r == ST_RUN) begin
        cycle_count_r <= cycle_count_r + 32'd1;
        if (halt_hit_s) begin
          halted_r <= 1'b1;
        end
        if (timeout_hit_s && !halt_hit_s) begin
          timeout_r <= 1'b1;
        end
        if (!legal_s && (instr_address != 32'h00000000)) begin
          addr_error_r <= 1'b1;
        end
      end
    end
  end

  // Program storage is deliberately not reset; valid_r masks stale contents
  always_ff @(posedge clk) begin
    if (reset && clk_enable && load_fire_s) begin
      mem_r[ptr_r] <= load_data;
    end
  end

  assign pipe_valid_s = (state_r != ST_LOAD);
  assign pipe_data_s  = pipe_valid_s ? fetch_s : NOP_WORD;

  mips_cpu_read_pipe #(
    .LATENCY (READ_LATENCY),
    .WIDTH   (33)
  ) u_read_pipe (
    .clk   (clk),
    .rst_n (reset),
    .en    (clk_enable),
    .din   ({pipe_valid_s, pipe_data_s}),
    .dout  ({instr_valid, instr_readdata})
  );

  assign load_ready  = (state_r == ST_LOAD);
  assign load_done   = load_done_r;
  assign halted      = halted_r;
  assign timeout     = timeout_r;
  assign addr_error  = addr_error_r;
  assign cycle_count = cycle_count_r;

endmodule
